// File: rtl/core_alu_mdu.sv
// core_alu_mdu: registered RV32I ALU plus iterative RV32M multiply/divide over an XLEN datapath.
// Define CORE_ALU_DIV_EN to compile in the restoring divider and its FSM state.
module core_alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic [6:0]      i_opcode,
    input  logic [6:0]      i_funct7,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_num1u,
    input  logic [XLEN-1:0] i_num2u,
    input  logic [XLEN-1:0] i_immu,
    input  logic [XLEN-1:0] i_pc_immu,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 2);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef CORE_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg;
    logic [2*XLEN-1:0]   acc_reg, acc_in, acc_step, mul_next, mul_full;
    logic [XLEN-1:0]     opb_reg, opb_in, mag1, mag2, opnd2, base_res, done_res;
    logic [XLEN:0]       mul_upper;
    logic [SHW-1:0]      shamt;
    logic [1:0]          f3_reg;
    logic                neg_reg, neg_in, sign1, sign2, signed1, signed2;
    logic                accept, m_op, mul_op, legal, alt_sub;
`ifdef CORE_ALU_DIV_EN
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     div_val, spec_res;
    logic                div_op, div_zero, div_ovf, div_special, step_div, is_div_reg;
`endif

    assign accept = i_valid && o_ready && !i_flush;
    assign m_op   = (i_opcode == OP_REG) && (i_funct7 == 7'b0000001);
    assign mul_op = m_op && !i_funct3[2];

    // Base ALU result, only consumed on accept
    always_comb begin
        opnd2    = (i_opcode == OP_IMM) ? i_immu : i_num2u;
        shamt    = opnd2[SHW-1:0];
        legal    = (i_opcode == OP_IMM) || (i_funct7 == 7'b0000000) ||
                   ((i_funct7 == 7'b0100000) && ((i_funct3 == 3'b000) || (i_funct3 == 3'b101)));
        alt_sub  = (i_opcode == OP_REG) && i_funct7[5];
        base_res = '0;
        if (i_opcode == OP_LUI) begin
            base_res = i_immu;
        end else if (i_opcode == OP_AUIPC) begin
            base_res = i_pc_immu;
        end else if (((i_opcode == OP_IMM) || (i_opcode == OP_REG)) && legal) begin
            case (i_funct3)
                3'b000: base_res = alt_sub ? (i_num1u - opnd2) : (i_num1u + opnd2);
                3'b001: base_res = i_num1u << shamt;
                3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(i_num1u) < $signed(opnd2))};
                3'b011: base_res = {{(XLEN-1){1'b0}}, (i_num1u < opnd2)};
                3'b100: base_res = i_num1u ^ opnd2;
                3'b101: base_res = i_funct7[5] ? $unsigned($signed(i_num1u) >>> shamt) : (i_num1u >> shamt);
                3'b110: base_res = i_num1u | opnd2;
                default: base_res = i_num1u & opnd2;
            endcase
        end
    end

    // Operand magnitudes and result sign for the M group
    always_comb begin
        signed1 = (i_funct3[1:0] == 2'b01) || (i_funct3[1:0] == 2'b10);
        signed2 = (i_funct3[1:0] == 2'b01);
`ifdef CORE_ALU_DIV_EN
        if (i_funct3[2]) begin
            signed1 = !i_funct3[0];
            signed2 = !i_funct3[0];
        end
`endif
        sign1  = signed1 && i_num1u[XLEN-1];
        sign2  = signed2 && i_num2u[XLEN-1];
        mag1   = sign1 ? -i_num1u : i_num1u;
        mag2   = sign2 ? -i_num2u : i_num2u;
        neg_in = sign1 ^ sign2;
`ifdef CORE_ALU_DIV_EN
        if (i_funct3[2] && i_funct3[1]) neg_in = sign1;
`endif
    end

    // One iteration; the first one runs on the accept edge from the fresh operands
    always_comb begin
        acc_in    = o_ready ? {{XLEN{1'b0}}, mag1} : acc_reg;
        opb_in    = o_ready ? mag2 : opb_reg;
        mul_upper = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opb_in} : {(XLEN+1){1'b0}});
        mul_next  = {mul_upper, acc_in[XLEN-1:1]};
        acc_step  = mul_next;
`ifdef CORE_ALU_DIV_EN
        trial    = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]} - {1'b0, opb_in};
        div_next = trial[XLEN] ? {acc_in[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        step_div = o_ready ? i_funct3[2] : (state_reg == S_DIV);
        if (step_div) acc_step = div_next;
`endif
    end

    always_comb begin
        mul_full = neg_reg ? -acc_reg : acc_reg;
        done_res = (f3_reg == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
`ifdef CORE_ALU_DIV_EN
        div_val = f3_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        if (is_div_reg) done_res = neg_reg ? -div_val : div_val;
`endif
    end

`ifdef CORE_ALU_DIV_EN
    always_comb begin
        div_op      = m_op && i_funct3[2];
        div_zero    = (i_num2u == '0);
        div_ovf     = !i_funct3[0] && (i_num1u == {1'b1, {(XLEN-1){1'b0}}}) && (&i_num2u);
        div_special = div_zero || div_ovf;
        spec_res    = div_zero ? (i_funct3[1] ? i_num1u : '1) : (i_funct3[1] ? '0 : i_num1u);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && mul_op) state_next = S_MUL;
`ifdef CORE_ALU_DIV_EN
                if (accept && div_op && !div_special) state_next = S_DIV;
`endif
            end
            S_MUL:  if (cnt_reg == CNT_LAST) state_next = S_DONE;
`ifdef CORE_ALU_DIV_EN
            S_DIV:  if (cnt_reg == CNT_LAST) state_next = S_DONE;
`endif
            default: state_next = S_IDLE;
        endcase
        if (i_flush) state_next = S_IDLE;
    end

    always_comb begin
        o_ready = (state_reg == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_res   <= '0;
            cnt_reg <= '0;
            acc_reg <= '0;
            opb_reg <= '0;
            f3_reg  <= '0;
            neg_reg <= 1'b0;
`ifdef CORE_ALU_DIV_EN
            is_div_reg <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cnt_reg <= '0;
                    if (accept) begin
                        acc_reg <= acc_step;
                        opb_reg <= mag2;
                        f3_reg  <= i_funct3[1:0];
                        neg_reg <= neg_in;
`ifdef CORE_ALU_DIV_EN
                        is_div_reg <= i_funct3[2];
                        if (div_op && div_special) begin
                            o_res   <= spec_res;
                            o_valid <= 1'b1;
                        end else
`endif
                        if (!mul_op
`ifdef CORE_ALU_DIV_EN
                            && !div_op
`endif
                        ) begin
                            o_res   <= base_res;
                            o_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!i_flush) begin
                        o_res   <= done_res;
                        o_valid <= 1'b1;
                    end
                end
                default: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_alu_mdu.sv
// tb_core_alu_mdu: directed checks of base ops, multiply/divide latency, flush and reset for core_alu_mdu.
module tb_core_alu_mdu;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_M     = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n, i_valid, i_flush, o_ready, o_valid;
    logic [6:0]  i_opcode, i_funct7;
    logic [2:0]  i_funct3;
    logic [31:0] i_num1u, i_num2u, i_immu, i_pc_immu, o_res;

    logic        w_valid, w_flush, w_ready, w_ovalid;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic [63:0] w_num1u, w_num2u, w_immu, w_pc_immu, w_res;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    core_alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_opcode(i_opcode), .i_funct7(i_funct7), .i_funct3(i_funct3),
        .i_num1u(i_num1u), .i_num2u(i_num2u), .i_immu(i_immu), .i_pc_immu(i_pc_immu),
        .o_valid(o_valid), .o_res(o_res)
    );

    core_alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_valid(w_valid), .o_ready(w_ready), .i_flush(w_flush),
        .i_opcode(w_opcode), .i_funct7(w_funct7), .i_funct3(w_funct3),
        .i_num1u(w_num1u), .i_num2u(w_num2u), .i_immu(w_immu), .i_pc_immu(w_pc_immu),
        .o_valid(w_ovalid), .o_res(w_res)
    );

    task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
        i_valid = 1'b1; i_opcode = op; i_funct7 = f7; i_funct3 = f3;
        i_num1u = a; i_num2u = b; i_immu = imm; i_pc_immu = pc;
    endtask

    task automatic idle();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_flush = 1'b0;
        w_valid = 1'b0; w_flush = 1'b0; w_opcode = '0; w_funct7 = '0; w_funct3 = '0;
        w_num1u = '0; w_num2u = '0; w_immu = '0; w_pc_immu = '0;
        drive(OP_REG, 7'd0, 3'b000, 32'd5, 32'd3, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || o_res !== 32'd0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b res=%h ready=%b, want 0/00000000/1", o_valid, o_res, o_ready);
        end
        vectors++;
        if (w_ovalid !== 1'b0 || w_res !== 64'd0 || w_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state64: valid=%b res=%h ready=%b, want 0/0/1", w_ovalid, w_res, w_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        idle();
        vectors++;
        if (o_valid !== 1'b1 || o_res !== 32'h8) begin
            miscompares++;
            $display("FAIL first_add: valid=%b res=%h, want 1/00000008", o_valid, o_res);
        end
        $display("reset: first ADD 5+3 -> %h", o_res);
    endtask

    task automatic test_base_back_to_back();
        vec_t v [15];
        v[0]  = '{OP_IMM, F7_ALT, 3'b101, 32'h80000000, 32'h0, 32'h00000404, 32'h0, 32'hF8000000};
        v[1]  = '{OP_IMM, 7'd0,   3'b011, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1};
        v[2]  = '{OP_REG, F7_ALT, 3'b000, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF};
        v[3]  = '{OP_IMM, 7'd0,   3'b000, 32'h10, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h0000000E};
        v[4]  = '{OP_REG, 7'd0,   3'b001, 32'h3, 32'h21, 32'h0, 32'h0, 32'h6};
        v[5]  = '{OP_REG, 7'd0,   3'b101, 32'h80000000, 32'h4, 32'h0, 32'h0, 32'h08000000};
        v[6]  = '{OP_REG, 7'd0,   3'b010, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h1};
        v[7]  = '{OP_REG, 7'd0,   3'b011, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0};
        v[8]  = '{OP_REG, 7'd0,   3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 32'h0FF00FF0};
        v[9]  = '{OP_REG, 7'd0,   3'b110, 32'hF0F0F0F0, 32'h0F000000, 32'h0, 32'h0, 32'hFFF0F0F0};
        v[10] = '{OP_IMM, 7'd0,   3'b111, 32'h12345678, 32'h0, 32'h0000FFFF, 32'h0, 32'h00005678};
        v[11] = '{OP_LUI, 7'd0,   3'b000, 32'h1, 32'h2, 32'hABCDE000, 32'h0, 32'hABCDE000};
        v[12] = '{OP_AUIPC, 7'd0, 3'b000, 32'h1, 32'h2, 32'h00001000, 32'h00401000, 32'h00401000};
        v[13] = '{7'd0,   7'd0,   3'b000, 32'h5, 32'h3, 32'h0, 32'h0, 32'h0};
        v[14] = '{OP_REG, 7'b0000010, 3'b000, 32'h5, 32'h3, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 15; i++) begin
            drive(v[i].op, v[i].f7, v[i].f3, v[i].a, v[i].b, v[i].imm, v[i].pc);
            @(negedge clk);
            vectors++;
            if (o_valid !== 1'b1 || o_res !== v[i].exp || o_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL base[%0d]: valid=%b res=%h ready=%b, want 1/%h/1", i, o_valid, o_res, o_ready, v[i].exp);
            end
            $display("base[%0d]: op=%b f3=%b a=%h b=%h imm=%h -> %h", i, v[i].op, v[i].f3, v[i].a, v[i].b, v[i].imm, o_res);
        end
        idle();
        @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL base_idle: valid=%b, want 0", o_valid);
        end
    endtask

    // Iterative op: o_ready low for cycles 1..32, result exactly at cycle 33
    task automatic run_iter(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input bit chain_add);
        drive(OP_REG, F7_M, f3, a, b, 32'd0, 32'd0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) idle();
            vectors++;
            if (k < 33) begin
                if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_busy cycle %0d: valid=%b ready=%b, want 0/0", name, k, o_valid, o_ready);
                end
            end else if (o_valid !== 1'b1 || o_ready !== 1'b1 || o_res !== exp) begin
                miscompares++;
                $display("FAIL %s_result: valid=%b ready=%b res=%h, want 1/1/%h", name, o_valid, o_ready, o_res, exp);
            end
        end
        $display("%s: a=%h b=%h -> %h", name, a, b, o_res);
        if (chain_add) drive(OP_REG, 7'd0, 3'b000, 32'd1, 32'd2, 32'd0, 32'd0);
        @(negedge clk);
        idle();
        vectors++;
        if (chain_add) begin
            if (o_valid !== 1'b1 || o_res !== 32'd3) begin
                miscompares++;
                $display("FAIL %s_chain_add: valid=%b res=%h, want 1/00000003", name, o_valid, o_res);
            end
        end else if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_single_pulse: valid=%b, want 0", name, o_valid);
        end
    endtask

    task automatic test_mul();
        run_iter("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_iter("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_iter("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        run_iter("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    endtask

    task automatic test_mul64();
        w_valid = 1'b1; w_opcode = OP_REG; w_funct7 = F7_M; w_funct3 = 3'b011;
        w_num1u = 64'h8000000000000000; w_num2u = 64'd4;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 1) w_valid = 1'b0;
            vectors++;
            if (k < 65) begin
                if (w_ovalid !== 1'b0 || w_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mulhu64_busy cycle %0d: valid=%b ready=%b, want 0/0", k, w_ovalid, w_ready);
                end
            end else if (w_ovalid !== 1'b1 || w_res !== 64'd2) begin
                miscompares++;
                $display("FAIL mulhu64_result: valid=%b res=%h, want 1/2", w_ovalid, w_res);
            end
        end
        $display("mulhu64: 2^63 x 4 -> %h", w_res);
    endtask

`ifdef CORE_ALU_DIV_EN
    task automatic test_div();
        vec_t s [4];
        run_iter("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
        run_iter("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_iter("divu", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        s[0] = '{OP_REG, F7_M, 3'b101, 32'd10, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
        s[1] = '{OP_REG, F7_M, 3'b111, 32'd10, 32'd0, 32'd0, 32'd0, 32'd10};
        s[2] = '{OP_REG, F7_M, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h80000000};
        s[3] = '{OP_REG, F7_M, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            drive(s[i].op, s[i].f7, s[i].f3, s[i].a, s[i].b, 32'd0, 32'd0);
            @(negedge clk);
            vectors++;
            if (o_valid !== 1'b1 || o_res !== s[i].exp || o_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL div_special[%0d]: valid=%b res=%h ready=%b, want 1/%h/1", i, o_valid, o_res, o_ready, s[i].exp);
            end
            $display("div_special[%0d]: f3=%b a=%h b=%h -> %h", i, s[i].f3, s[i].a, s[i].b, o_res);
        end
        idle();
        @(negedge clk);
    endtask
`else
    task automatic test_macro_off();
        drive(OP_REG, F7_M, 3'b100, 32'd10, 32'd2, 32'd0, 32'd0);
        @(negedge clk);
        idle();
        vectors++;
        if (o_valid !== 1'b1 || o_res !== 32'd0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL div_disabled: valid=%b res=%h ready=%b, want 1/00000000/1", o_valid, o_res, o_ready);
        end
        @(negedge clk);
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL div_disabled_after: ready=%b valid=%b, want 1/0", o_ready, o_valid);
        end
        $display("div_disabled: DIV 10/2 -> %h", o_res);
    endtask
`endif

    task automatic test_flush();
        bit seen;
`ifdef CORE_ALU_DIV_EN
        drive(OP_REG, F7_M, 3'b101, 32'd100, 32'd7, 32'd0, 32'd0);
`else
        drive(OP_REG, F7_M, 3'b011, 32'd100, 32'd7, 32'd0, 32'd0);
`endif
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) idle();
        end
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: ready=%b valid=%b, want 1/0", o_ready, o_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_result: saw valid=1, want none");
        end
        drive(OP_REG, 7'd0, 3'b000, 32'd5, 32'd3, 32'd0, 32'd0);
        i_flush = 1'b1;
        @(negedge clk);
        idle();
        i_flush = 1'b0;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop_add: valid=%b, want 0", o_valid);
        end
        $display("flush: in-flight op and same-cycle ADD dropped, ready=%b", o_ready);
        drive(OP_REG, F7_M, 3'b000, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) idle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (o_valid !== 1'b0 || o_res !== 32'd0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_midop: valid=%b res=%h ready=%b, want 0/00000000/1", o_valid, o_res, o_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midop_no_result: saw valid=1, want none");
        end
        $display("reset mid-op: outputs cleared, res=%h", o_res);
    endtask

    initial begin
        test_reset();
        test_base_back_to_back();
        test_mul();
        test_mul64();
`ifdef CORE_ALU_DIV_EN
        test_div();
`else
        test_macro_off();
`endif
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_alu_mdu.md
# core_alu_mdu

Parametrised, registered successor to the single-cycle integer ALU in the RV32I core: executes all RV32I ALU operations plus the RV32M multiply/divide group for an XLEN-wide datapath. Sits in the EX stage; base operations complete in one cycle, multiply/divide iterate over XLEN cycles behind a valid/ready handshake, so the pipeline stalls on `o_ready` low. Decode inputs (opcode/funct7/funct3) keep the same meaning and encoding as the existing ALU.

## Interface
- `XLEN`, 32: datapath width; legal values 32, 64; shift amount uses low log2(XLEN) bits.
- `clk`  input  1  core clock; all state changes on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `i_valid`  input  1  operation present on decode/operand inputs.
- `o_ready`  output  1  unit can accept an operation this cycle.
- `i_flush`  input  1  abort in-flight operation (pipeline flush).
- `i_opcode`, `i_funct7`  input  7 each  instruction fields.
- `i_funct3`  input  3  instruction field.
- `i_num1u`, `i_num2u`  input  XLEN  rs1/rs2 operands, unsigned view.
- `i_immu`, `i_pc_immu`  input  XLEN  sign-extended immediate; PC+imm for AUIPC.
- `o_valid`  output  1  one-cycle pulse: `o_res` holds a completed result.
- `o_res`  output  XLEN  result; held until next completion.

## Operation
- Accept = `i_valid && o_ready && !i_flush`; inputs sampled only on accept.
- Base ops (LUI, AUIPC, ADD/ADDI, SUB, XOR/OR/AND(+I), SLL/SRL/SRA(+I), SLT/SLTU(+I)): same results as existing ALU, widened to XLEN; SRA/SRAI arithmetic; unmatched decode → result 0. Registered into `o_res`, `o_valid` next cycle; no busy state.
- M ops (opcode 0110011, funct7 0000001): funct3 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM: IDLE → MUL or DIV on accepted M op; MUL/DIV run XLEN iterations (counter 0..XLEN-1) → DONE → IDLE. `o_ready`=1 only in IDLE.
- MUL: operands converted to magnitudes per signedness, radix-2 shift-add into 2·XLEN product, two's-complement negate at DONE if signs differ; select low or high half.
- DIV: restoring, one quotient bit per cycle, on magnitudes; quotient sign = sign1 XOR sign2, remainder sign = dividend sign.
- Division special cases bypass iteration (one-cycle like base ops): divisor 0 → quotient all-ones, remainder = dividend; signed overflow (−2^(XLEN−1) ÷ −1) → quotient = dividend, remainder 0.
- `i_flush`: any state → IDLE next edge, no `o_valid` for aborted op; flush with `i_valid` same cycle → op dropped.
- Reset mid-operation: identical to flush, plus outputs to reset values.

## Timing
- Reset values: `o_valid`=0, `o_res`=0, `o_ready`=1, FSM=IDLE, counter=0.
- Base op / special-case divide: accept at edge N, `o_valid`=1 in cycle N+1.
- MUL*/DIV*/REM*: accept at edge N, `o_ready`=0 from N+1, `o_valid`=1 in cycle N+XLEN+1, `o_ready`=1 in same cycle; total latency XLEN+1.
- Back-to-back base ops: one accept per cycle, one `o_valid` per cycle.
- Accept permitted in the cycle `o_valid` is high (from IDLE).
- `o_valid` never asserted two consecutive cycles for the same op; no backpressure on output.

## Configuration
- `CORE_ALU_DIV_EN` defined: divider datapath and DIV FSM state compiled in; DIV/DIVU/REM/REMU as above.
- Not defined: divider logic removed; funct3 1xx M ops treated as base ops with unmatched decode → `o_res`=0, `o_valid` next cycle, `o_ready` never drops. MUL group unaffected.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `i_valid`=1 ADD → `o_valid`=0, `o_res`=0, `o_ready`=1; first accept after release gives 0x5+0x3 → 0x8 next cycle.
- Base ops XLEN=32: SRAI 0x80000000 by 4 → 0xF8000000; SLTIU 1 vs imm 0xFFFFFFFF → 1; SUB 0 − 1 → 0xFFFFFFFF; back-to-back, one result per cycle.
- Multiply: MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000; MULHU same → 0xFFFFFFFE; MUL 7 × −3 → 0xFFFFFFEB; `o_valid` exactly 33 cycles after accept, `o_ready` low in between.
- Divide (`CORE_ALU_DIV_EN`): DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 10/0 → 0xFFFFFFFF, REMU 10/0 → 10 in one cycle; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Flush: accept DIVU, assert `i_flush` at cycle 10 → no `o_valid`, `o_ready`=1 next cycle; `i_flush` with `i_valid` ADD same cycle → no result.
- Macro off: DIV 10/2 → `o_res`=0 next cycle, `o_ready` stays 1; XLEN=64 MULHU 2^63 × 4 → 2.
